// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: opcodes, register file geometry,
// and bit offsets of the IF_ID and ID_EX pipeline registers.
package cpu_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 8;

  typedef enum logic [3:0] {
    OP_MV   = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_CMP  = 4'd3,
    OP_LD   = 4'd4,
    OP_ST   = 4'd5,
    OP_MVHI = 4'd6,
    OP_J    = 4'd8,
    OP_JZ   = 4'd9,
    OP_JN   = 4'd10,
    OP_CALL = 4'd12
  } opcode_e;

  localparam int IFID_PC_LSB    = 0;
  localparam int IFID_INSTR_LSB = 16;

  localparam int IDEX_PC_LSB  = 0;
  localparam int IDEX_RX_LSB  = 16;
  localparam int IDEX_RY_LSB  = 32;
  localparam int IDEX_IMM_LSB = 48;
  localparam int IDEX_RD_LSB  = 64;
  localparam int IDEX_OP_LSB  = 67;
  localparam int IDEX_VLD_BIT = 71;
  localparam int IDEX_WB_BIT  = 72;
  localparam int IDEX_MRD_BIT = 73;
  localparam int IDEX_MWR_BIT = 74;
  localparam int IDEX_MIN_W   = 75;

endpackage

// File: rtl/datapath_regfile.sv
// 8x16 register file: two combinational read ports, one write port, async clear.
// Build with DECODE_WB_BYPASS_EN to forward same-cycle write data to the read ports.
module datapath_regfile
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_reg,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [REG_IDX_W-1:0] rd_a_reg,
  input  logic [REG_IDX_W-1:0] rd_b_reg,
  output logic [DATA_W-1:0]    rd_a_data,
  output logic [DATA_W-1:0]    rd_b_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_reg] <= wr_data;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rd_a_data = (wr_en && (wr_reg == rd_a_reg)) ? wr_data : regs[rd_a_reg];
  assign rd_b_data = (wr_en && (wr_reg == rd_b_reg)) ? wr_data : regs[rd_b_reg];
`else
  assign rd_a_data = regs[rd_a_reg];
  assign rd_b_data = regs[rd_b_reg];
`endif

endmodule

// File: rtl/datapath_decode.sv
// Decode / register-read stage: decodes IF_ID, reads the register file, detects hazards,
// and registers ID_EX. DECODE_WB_BYPASS_EN selects write-through reads instead of a stall.
module datapath_decode
  import cpu_pkg::*;
#(
  parameter int ID_EX_WIDTH = IDEX_MIN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            IF_ID,
  input  logic                   i_wb_en,
  input  logic [REG_IDX_W-1:0]   i_wb_reg,
  input  logic [DATA_W-1:0]      i_wb_data,
  input  logic                   i_flush,
  output logic                   o_stall,
  output logic [ID_EX_WIDTH-1:0] ID_EX
);

  function automatic logic signed [DATA_W-1:0] sext8(input logic [7:0] v);
    return $signed({{8{v[7]}}, v});
  endfunction

  function automatic logic signed [DATA_W-1:0] sext11(input logic [10:0] v);
    return $signed({{5{v[10]}}, v});
  endfunction

  logic [15:0]            instr, pc2;
  logic [3:0]             opcode;
  logic                   imm_f;
  logic [REG_IDX_W-1:0]   rx, ry, rd;
  logic                   use_rx, use_ry, wb_en, mem_rd, mem_wr, is_br;
  logic signed [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0]      rx_data, ry_data;
  logic                   load_use, wb_hazard, hazard, bubble;
  logic [IDEX_MIN_W-1:0]  id_ex_d, id_ex_p1;
  logic                   vld_p1;

  assign instr  = IF_ID[IFID_INSTR_LSB +: 16];
  assign pc2    = IF_ID[IFID_PC_LSB +: 16];
  assign opcode = instr[3:0];
  assign imm_f  = instr[4];
  assign rx     = instr[7:5];
  assign ry     = instr[10:8];

  always_comb begin
    use_rx = 1'b0;
    use_ry = 1'b0;
    wb_en  = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    is_br  = 1'b0;
    rd     = rx;
    case (opcode)
      OP_MV:          begin use_ry = ~imm_f; wb_en = 1'b1; end
      OP_ADD, OP_SUB: begin use_rx = 1'b1; use_ry = ~imm_f; wb_en = 1'b1; end
      OP_CMP:         begin use_rx = 1'b1; use_ry = ~imm_f; end
      OP_LD:          begin use_ry = 1'b1; wb_en = 1'b1; mem_rd = 1'b1; end
      OP_ST:          begin use_rx = 1'b1; use_ry = 1'b1; mem_wr = 1'b1; end
      OP_MVHI:        begin use_rx = 1'b1; wb_en = 1'b1; end
      OP_J, OP_JZ, OP_JN: begin is_br = 1'b1; use_rx = ~imm_f; end
      OP_CALL:        begin is_br = 1'b1; use_rx = ~imm_f; wb_en = 1'b1; rd = 3'd7; end
      default: ;
    endcase
  end

  assign imm_s = (is_br && imm_f) ? sext11(instr[15:5]) : sext8(instr[15:8]);

  datapath_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (i_wb_en),
    .wr_reg    (i_wb_reg),
    .wr_data   (i_wb_data),
    .rd_a_reg  (rx),
    .rd_b_reg  (ry),
    .rd_a_data (rx_data),
    .rd_b_data (ry_data)
  );

  assign vld_p1   = id_ex_p1[IDEX_VLD_BIT];
  assign load_use = vld_p1 && id_ex_p1[IDEX_MRD_BIT] &&
                    ((use_rx && (id_ex_p1[IDEX_RD_LSB +: 3] == rx)) ||
                     (use_ry && (id_ex_p1[IDEX_RD_LSB +: 3] == ry)));

`ifdef DECODE_WB_BYPASS_EN
  assign wb_hazard = 1'b0;
`else
  // Without forwarding, a same-cycle writeback to a source would be read stale.
  assign wb_hazard = i_wb_en && ((use_rx && (i_wb_reg == rx)) ||
                                 (use_ry && (i_wb_reg == ry)));
`endif

  assign hazard  = load_use || wb_hazard;
  assign o_stall = hazard && !i_flush;
  assign bubble  = hazard || i_flush;

  always_comb begin
    id_ex_d = '0;
    if (!bubble) begin
      id_ex_d[IDEX_PC_LSB  +: 16] = pc2;
      id_ex_d[IDEX_RX_LSB  +: 16] = rx_data;
      id_ex_d[IDEX_RY_LSB  +: 16] = ry_data;
      id_ex_d[IDEX_IMM_LSB +: 16] = imm_s;
      id_ex_d[IDEX_RD_LSB  +: 3]  = rd;
      id_ex_d[IDEX_OP_LSB  +: 4]  = opcode;
      id_ex_d[IDEX_VLD_BIT]       = 1'b1;
      id_ex_d[IDEX_WB_BIT]        = wb_en;
      id_ex_d[IDEX_MRD_BIT]       = mem_rd;
      id_ex_d[IDEX_MWR_BIT]       = mem_wr;
    end
  end

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) id_ex_p1 <= '0;
    else       id_ex_p1 <= id_ex_d;
  end

  assign ID_EX = ID_EX_WIDTH'(id_ex_p1);

endmodule

// File: tb/tb_datapath_decode.sv
// Directed self-checking bench for datapath_decode; covers both DECODE_WB_BYPASS_EN builds.
module tb_datapath_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_id;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        flush;
  logic        stall;
  logic [74:0] id_ex;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  datapath_decode #(.ID_EX_WIDTH(75)) dut (
    .clk       (clk),
    .reset     (reset),
    .IF_ID     (if_id),
    .i_wb_en   (wb_en),
    .i_wb_reg  (wb_reg),
    .i_wb_data (wb_data),
    .i_flush   (flush),
    .o_stall   (stall),
    .ID_EX     (id_ex)
  );

  wire [15:0] f_pc  = id_ex[15:0];
  wire [15:0] f_rx  = id_ex[31:16];
  wire [15:0] f_ry  = id_ex[47:32];
  wire [15:0] f_imm = id_ex[63:48];
  wire [2:0]  f_rd  = id_ex[66:64];
  wire [3:0]  f_op  = id_ex[70:67];
  wire        f_vld = id_ex[71];
  wire        f_wb  = id_ex[72];
  wire        f_mrd = id_ex[73];
  wire        f_mwr = id_ex[74];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; if_id = '0; wb_en = 1'b0; wb_reg = '0; wb_data = '0; flush = 1'b0;
    #2;
    chk("reset_idex", id_ex, 0);
    chk("reset_stall", stall, 0);
    edge_settle();
    edge_settle();
    chk("reset_idex_held", id_ex, 0);
    @(negedge clk) reset = 1'b0;

    // r3 <- 0x1234 while mv r0,r0 decodes
    wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'h1234; if_id = 32'h0000_0000;
    #1 chk("mv_r0_nostall", stall, 0);
    edge_settle();
    chk("mv_r0_vld", f_vld, 1);
    chk("mv_r0_wb", f_wb, 1);

    // add r1,r3
    @(negedge clk) wb_en = 1'b0; if_id = {16'h0321, 16'h0102};
    #1 chk("add_nostall", stall, 0);
    edge_settle();
    chk("add_ry", f_ry, 16'h1234);
    chk("add_rx", f_rx, 16'h0000);
    chk("add_rd", f_rd, 1);
    chk("add_wb", f_wb, 1);
    chk("add_vld", f_vld, 1);
    chk("add_op", f_op, 1);
    chk("add_pc", f_pc, 16'h0102);

    // mv r5,r2 with simultaneous r2 <- 0xBEEF
    @(negedge clk) wb_en = 1'b1; wb_reg = 3'd2; wb_data = 16'hBEEF; if_id = {16'h02A0, 16'h0104};
`ifdef DECODE_WB_BYPASS_EN
    #1 chk("byp_nostall", stall, 0);
    edge_settle();
    chk("byp_ry", f_ry, 16'hBEEF);
    chk("byp_rd", f_rd, 5);
    chk("byp_vld", f_vld, 1);
    @(negedge clk) wb_en = 1'b0;
`else
    #1 chk("wbhaz_stall", stall, 1);
    edge_settle();
    chk("wbhaz_bubble", id_ex, 0);
    @(negedge clk) wb_en = 1'b0;
    #1 chk("wbhaz_retry_nostall", stall, 0);
    edge_settle();
    chk("wbhaz_retry_ry", f_ry, 16'hBEEF);
    chk("wbhaz_retry_rd", f_rd, 5);
    chk("wbhaz_retry_vld", f_vld, 1);
`endif

    // ld r4,[r1] then add r4,r4: load-use
    @(negedge clk) if_id = {16'h0184, 16'h0106};
    #1 chk("ld_nostall", stall, 0);
    edge_settle();
    chk("ld_mrd", f_mrd, 1);
    chk("ld_rd", f_rd, 4);
    chk("ld_op", f_op, 4);
    chk("ld_wb", f_wb, 1);
    @(negedge clk) if_id = {16'h0481, 16'h0108};
    #1 chk("lu_stall", stall, 1);
    edge_settle();
    chk("lu_bubble", id_ex, 0);
    @(negedge clk);
    #1 chk("lu_stall_clear", stall, 0);
    edge_settle();
    chk("lu_issue_vld", f_vld, 1);
    chk("lu_issue_op", f_op, 1);
    chk("lu_issue_pc", f_pc, 16'h0108);

    // load-use hazard overridden by flush
    @(negedge clk) if_id = {16'h0184, 16'h010A};
    edge_settle();
    @(negedge clk) if_id = {16'h0481, 16'h010C}; flush = 1'b1;
    #1 chk("flush_nostall", stall, 0);
    edge_settle();
    chk("flush_bubble", id_ex, 0);
    @(negedge clk) flush = 1'b0;

    // mv r1,#0xFF
    if_id = {16'hFF30, 16'h010E};
    edge_settle();
    chk("mvi_imm", f_imm, 16'hFFFF);
    chk("mvi_rd", f_rd, 1);

    // st r2,[r3]
    @(negedge clk) if_id = {16'h0345, 16'h0110};
    edge_settle();
    chk("st_rx", f_rx, 16'hBEEF);
    chk("st_ry", f_ry, 16'h1234);
    chk("st_mwr", f_mwr, 1);
    chk("st_wb", f_wb, 0);

    // call #5 (imm11)
    @(negedge clk) if_id = {16'h00BC, 16'h0112};
    edge_settle();
    chk("call_rd", f_rd, 7);
    chk("call_wb", f_wb, 1);
    chk("call_imm", f_imm, 16'h0005);

    // undefined opcode 7
    @(negedge clk) if_id = {16'h0007, 16'h0114};
    edge_settle();
    chk("undef_vld", f_vld, 1);
    chk("undef_ctl", {f_wb, f_mrd, f_mwr}, 3'b000);

    // j with imm11 = 0x400
    @(negedge clk) if_id = {16'h8018, 16'h0116};
    edge_settle();
    chk("j_imm", f_imm, 16'hFC00);
    chk("j_wb", f_wb, 0);

    // reset asserted in the middle of a load-use stall
    @(negedge clk) if_id = {16'h0184, 16'h0118};
    edge_settle();
    @(negedge clk) if_id = {16'h0481, 16'h011A};
    #1 chk("rst_pre_stall", stall, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_idex", id_ex, 0);
    chk("rst_async_stall", stall, 0);
    @(negedge clk) reset = 1'b0; if_id = {16'h0321, 16'h011C};
    edge_settle();
    chk("rst_r3_cleared", f_ry, 16'h0000);
    chk("rst_after_vld", f_vld, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
